// File: rtl/axis_pkt_framer_if.sv
`default_nettype none
// ============================================================================
//  Module      : axis_pkt_framer_if
//  Description : 16-bit AXI-Stream bundle used on both sides of the packet
//                framer. The master drives valid/data/last, the slave
//                drives ready.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axis_pkt_framer_if;
    logic        tvaild;
    logic        tready;
    logic [15:0] tdata;
    logic        tlast;

    modport master (output tvaild, output tdata, output tlast, input tready);
    modport slave  (input tvaild, input tdata, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_pkt_framer.sv
`default_nettype none
// ============================================================================
//  Module      : axis_pkt_framer
//  Description : Store-and-forward framer. Buffers one tlast-delimited packet
//                (truncated at MAX_LEN words), then emits
//                SYNC_WORD, {trunc, len}, payload..., checksum on a stream
//                without tlast so boundaries survive a tlast-less FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_pkt_framer #(
    parameter int          MAX_LEN   = 256,
    parameter int          ADDR_W    = 8,
    parameter logic [15:0] SYNC_WORD = 16'hA5A5
) (
    input  logic                 clk,
    input  logic                 rst,
    axis_pkt_framer_if.slave     s_axis,
    axis_pkt_framer_if.master    m_axis,
    output logic [15:0]          pkt_cnt,
    output logic [15:0]          trunc_cnt,
    output logic                 busy
);

    typedef enum logic [2:0] {
        ST_FILL    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CSUM    = 3'd4
    } state_t;

    state_t              state_q;

    // Packet buffer and its registered read port
    logic [15:0]         mem_q [MAX_LEN];
    logic [15:0]         rdata_q;

    // Packet bookkeeping
    logic [14:0]         len_q;
    logic [14:0]         pay_idx_q;
    logic [15:0]         sum_q;
    logic                trunc_q;
    logic [ADDR_W-1:0]   rd_ptr_q;

    // Registered outputs
    logic                s_tready_q;
    logic                m_tvalid_q;
    logic [15:0]         m_tdata_q;
    logic                busy_q;
    logic [15:0]         pkt_cnt_q;
    logic [15:0]         trunc_cnt_q;

    logic                w_in_hs;
    logic                w_out_hs;
    logic [14:0]         w_len_inc;
    logic                w_full;
    logic                w_last_pay;
    logic                w_ren;
    logic [ADDR_W-1:0]   w_raddr;

    // s_tready_q is only ever high in FILL, so an input handshake implies FILL
    assign w_in_hs    = s_tready_q & s_axis.tvaild;
    assign w_out_hs   = m_tvalid_q & m_axis.tready;
    assign w_len_inc  = len_q + 15'd1;
    assign w_full     = (w_len_inc == 15'(MAX_LEN));
    assign w_last_pay = (pay_idx_q == (len_q - 15'd1));

    // Read-port control: rdata_q always holds the next payload word to be
    // loaded into the output register, and advances only when that word is
    // consumed, so output stalls never lose the prefetched word.
    always_comb begin
        w_ren   = 1'b0;
        w_raddr = rd_ptr_q;
        case (state_q)
            ST_SYNC: begin
                w_ren   = 1'b1;
                w_raddr = '0;
            end
            ST_LEN:     w_ren = w_out_hs;
            ST_PAYLOAD: w_ren = w_out_hs & ~w_last_pay;
            default:    w_ren = 1'b0;
        endcase
    end

    // Buffer RAM: write during FILL, synchronous read for the drain side
    always_ff @(posedge clk) begin
        if (w_in_hs) begin
            mem_q[len_q[ADDR_W-1:0]] <= s_axis.tdata;
        end
        if (w_ren) begin
            rdata_q <= mem_q[w_raddr];
        end
    end

    // Framing state machine with registered stream outputs and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FILL;
            s_tready_q  <= 1'b0;
            m_tvalid_q  <= 1'b0;
            m_tdata_q   <= 16'h0000;
            busy_q      <= 1'b0;
            pkt_cnt_q   <= 16'h0000;
            trunc_cnt_q <= 16'h0000;
            len_q       <= '0;
            pay_idx_q   <= '0;
            sum_q       <= 16'h0000;
            trunc_q     <= 1'b0;
            rd_ptr_q    <= '0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    s_tready_q <= 1'b1;
                    if (w_in_hs) begin
                        len_q <= w_len_inc;
                        sum_q <= sum_q + s_axis.tdata;
                        if (s_axis.tlast || w_full) begin
                            state_q    <= ST_SYNC;
                            s_tready_q <= 1'b0;
                            busy_q     <= 1'b1;
                            m_tvalid_q <= 1'b1;
                            m_tdata_q  <= SYNC_WORD;
                            trunc_q    <= ~s_axis.tlast;
                            if (!s_axis.tlast) begin
                                trunc_cnt_q <= trunc_cnt_q + 16'd1;
                            end
                        end
                    end
                end
                ST_SYNC: begin
                    // buf[0] is being fetched this cycle; buf[1] comes next
                    rd_ptr_q <= ADDR_W'(1);
                    if (w_out_hs) begin
                        state_q   <= ST_LEN;
                        m_tdata_q <= {trunc_q, len_q};
                    end
                end
                ST_LEN: begin
                    if (w_out_hs) begin
                        state_q   <= ST_PAYLOAD;
                        m_tdata_q <= rdata_q;
                        pay_idx_q <= '0;
                        rd_ptr_q  <= rd_ptr_q + ADDR_W'(1);
                    end
                end
                ST_PAYLOAD: begin
                    if (w_out_hs) begin
                        if (w_last_pay) begin
                            state_q   <= ST_CSUM;
                            m_tdata_q <= 16'h0000 - sum_q;
                        end else begin
                            m_tdata_q <= rdata_q;
                            pay_idx_q <= pay_idx_q + 15'd1;
                            rd_ptr_q  <= rd_ptr_q + ADDR_W'(1);
                        end
                    end
                end
                ST_CSUM: begin
                    if (w_out_hs) begin
                        state_q    <= ST_FILL;
                        m_tvalid_q <= 1'b0;
                        m_tdata_q  <= 16'h0000;
                        busy_q     <= 1'b0;
                        s_tready_q <= 1'b1;
                        pkt_cnt_q  <= pkt_cnt_q + 16'd1;
                        len_q      <= '0;
                        sum_q      <= 16'h0000;
                        trunc_q    <= 1'b0;
                    end
                end
                default: state_q <= ST_FILL;
            endcase
        end
    end

    assign s_axis.tready = s_tready_q;
    assign m_axis.tvaild = m_tvalid_q;
    assign m_axis.tdata  = m_tdata_q;
    assign m_axis.tlast  = 1'b0;
    assign pkt_cnt       = pkt_cnt_q;
    assign trunc_cnt     = trunc_cnt_q;
    assign busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_pkt_framer
//  Description : Self-checking bench for axis_pkt_framer. A packet-level
//                model turns every accepted input word into expected frame
//                words; a monitor compares the output stream and protocol.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_pkt_framer;

    localparam int          MAX_LEN = 8;
    localparam int          ADDR_W  = 3;
    localparam logic [15:0] SYNC    = 16'hA5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pkt_cnt;
    logic [15:0] trunc_cnt;
    logic        busy;

    axis_pkt_framer_if s_if ();
    axis_pkt_framer_if m_if ();

    axis_pkt_framer #(
        .MAX_LEN   (MAX_LEN),
        .ADDR_W    (ADDR_W),
        .SYNC_WORD (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_axis    (s_if),
        .m_axis    (m_if),
        .pkt_cnt   (pkt_cnt),
        .trunc_cnt (trunc_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] exp_q [$];
    logic [15:0] pkt_q [$];
    int          model_truncs = 0;
    int          done_frames  = 0;

    // Accepts one input word; when it closes a packet, appends the whole frame
    function automatic bit model_push(input logic [15:0] d, input logic l);
        int          s;
        logic [15:0] lw;
        pkt_q.push_back(d);
        if (l || pkt_q.size() == MAX_LEN) begin
            s  = 0;
            lw = {~l, 15'(pkt_q.size())};
            exp_q.push_back(SYNC);
            exp_q.push_back(lw);
            foreach (pkt_q[i]) begin
                exp_q.push_back(pkt_q[i]);
                s += int'(pkt_q[i]);
            end
            exp_q.push_back(16'((65536 - (s % 65536)) % 65536));
            if (!l) model_truncs++;
            pkt_q.delete();
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // ---------------- output monitor ----------------
    bit          mon_en    = 0;
    bit          chk_turn  = 0;
    bit          hold_pend = 0;
    logic [15:0] hold_d    = '0;
    int          frame_left = 0;

    always @(negedge clk) begin
        logic [15:0] e;
        logic [15:0] lw;
        if (mon_en) begin
            if (chk_turn) begin
                chk("turn_rdy",  {31'd0, s_if.tready}, 1);
                chk("turn_busy", {31'd0, busy}, 0);
                chk("pkt_cnt",   {16'd0, pkt_cnt}, {16'd0, done_frames[15:0]});
                chk("trunc_cnt", {16'd0, trunc_cnt}, {16'd0, model_truncs[15:0]});
                chk_turn = 0;
            end
            if (frame_left > 0) chk("no_bubble", {31'd0, m_if.tvaild}, 1);
            if (hold_pend) begin
                chk("hold_v", {31'd0, m_if.tvaild}, 1);
                chk("hold_d", {16'd0, m_if.tdata}, {16'd0, hold_d});
            end
            if (m_if.tvaild) begin
                chk("drain_rdy",  {31'd0, s_if.tready}, 0);
                chk("drain_busy", {31'd0, busy}, 1);
            end
            hold_pend = m_if.tvaild && !m_if.tready;
            hold_d    = m_if.tdata;
            if (m_if.tvaild && m_if.tready) begin
                chk("out_expected", {31'd0, exp_q.size() > 0}, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("out_data", {16'd0, m_if.tdata}, {16'd0, e});
                    if (frame_left == 0) begin
                        if (exp_q.size() > 0) begin
                            lw = exp_q[0];
                            frame_left = int'(lw[14:0]) + 2;
                        end
                    end else begin
                        frame_left--;
                        if (frame_left == 0) begin
                            done_frames++;
                            chk_turn = 1;
                        end
                    end
                end
            end
        end
    end

    // ---------------- downstream ready generator ----------------
    int rdy_pct = 100;
    initial begin
        m_if.tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_if.tready = ($urandom_range(0, 99) < rdy_pct);
        end
    end

    // ---------------- input driver ----------------
    task automatic send_word(input logic [15:0] d, input logic l);
        int n;
        bit closing;
        s_if.tvaild = 1'b1;
        s_if.tdata  = d;
        s_if.tlast  = l;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_if.tready && n < 3000);
        if (!s_if.tready) begin
            chk("in_timeout", 0, 1);
            s_if.tvaild = 1'b0;
            return;
        end
        closing = model_push(d, l);
        @(posedge clk);
        #1;
        s_if.tvaild = 1'b0;
        if (closing) begin
            chk("sync_lat_v", {31'd0, m_if.tvaild}, 1);
            chk("sync_lat_d", {16'd0, m_if.tdata}, {16'd0, SYNC});
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || frame_left != 0) && n < 5000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain_done", {31'd0, exp_q.size() == 0 && frame_left == 0}, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          n;
        int          len;
        logic [15:0] w;

        s_if.tvaild = 1'b0;
        s_if.tdata  = 16'h0000;
        s_if.tlast  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_rdy",   {31'd0, s_if.tready}, 0);
        chk("rst_m_vld",   {31'd0, m_if.tvaild}, 0);
        chk("rst_m_data",  {16'd0, m_if.tdata}, 0);
        chk("rst_pkt",     {16'd0, pkt_cnt}, 0);
        chk("rst_trunc",   {16'd0, trunc_cnt}, 0);
        chk("rst_busy",    {31'd0, busy}, 0);
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1;
        #1;
        chk("rel_rdy_hold", {31'd0, s_if.tready}, 0);
        @(posedge clk);
        #1;
        chk("rel_rdy", {31'd0, s_if.tready}, 1);

        // 1: ramp packet, no backpressure
        rdy_pct = 100;
        for (int i = 1; i <= 4; i++) send_word(16'(i), i == 4);
        wait_drain();
        chk("t1_pkt_cnt", {16'd0, pkt_cnt}, 1);

        // 2: single-word packet
        send_word(16'h1234, 1'b1);
        wait_drain();

        // 3: ramp packet with 50% backpressure
        rdy_pct = 50;
        for (int i = 1; i <= 4; i++) send_word(16'(i), i == 4);
        wait_drain();

        // 4/5: truncation with input held valid while the frame drains
        rdy_pct = 100;
        for (int i = 0; i < 10; i++) send_word(16'(i), i == 9);
        wait_drain();
        chk("t4_trunc_cnt", {16'd0, trunc_cnt}, 1);
        chk("t4_pkt_cnt",   {16'd0, pkt_cnt}, 5);

        // randomized packets, lengths beyond MAX_LEN included
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 12);
            case ($urandom_range(0, 2))
                0:       rdy_pct = 30;
                1:       rdy_pct = 70;
                default: rdy_pct = 100;
            endcase
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
                w = 16'($urandom);
                send_word(w, i == len - 1);
            end
        end
        wait_drain();
        chk("rand_pkt_cnt", {16'd0, pkt_cnt}, {16'd0, done_frames[15:0]});

        // 6: reset in the middle of the payload
        rdy_pct = 100;
        for (int i = 0; i < 6; i++) send_word(16'h0100 + 16'(i), i == 5);
        n = 0;
        while (frame_left != 4 && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("t6_reach_payload", frame_left, 4);
        rst = 1'b1;
        #1;
        chk("t6_async_vld",  {31'd0, m_if.tvaild}, 0);
        chk("t6_async_busy", {31'd0, busy}, 0);
        mon_en     = 0;
        exp_q.delete();
        pkt_q.delete();
        frame_left   = 0;
        hold_pend    = 0;
        chk_turn     = 0;
        done_frames  = 0;
        model_truncs = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1;
        @(posedge clk);
        #1;
        chk("t6_rdy",   {31'd0, s_if.tready}, 1);
        chk("t6_pkt",   {16'd0, pkt_cnt}, 0);
        chk("t6_trunc", {16'd0, trunc_cnt}, 0);
        for (int i = 0; i < 3; i++) send_word(16'hBEE0 + 16'(i), i == 2);
        wait_drain();
        chk("t6_post_pkt", {16'd0, pkt_cnt}, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
